// File: rtl/raster_scheduler.sv
// raster_scheduler: frame-level sequencer that walks the projected-particle
// memory, culls off-screen or zero-radius records and issues the rest to the
// rasterizer one at a time.
//   clk_in, rst_in (async, active-low)
//   frame_start_in/particle_count_in : frame request (accepted only in IDLE)
//   mem_rd_out/mem_addr_out/mem_data_in : particle memory read port
//   rast_ready_in/rast_valid_out/rast_*_out : rasterizer handshake and fields
//   busy_out/frame_done_out/issued_count_out/culled_count_out : frame status
module raster_scheduler #(
    parameter int MAX_PARTICLES = 1024,
    parameter int ADDR_WIDTH    = 10,
    parameter int WIDTH         = 320,
    parameter int HEIGHT        = 180,
    parameter int MEM_LATENCY   = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  frame_start_in,
    input  logic [ADDR_WIDTH:0]   particle_count_in,
    output logic                  mem_rd_out,
    output logic [ADDR_WIDTH-1:0] mem_addr_out,
    input  logic [52:0]           mem_data_in,
    input  logic                  rast_ready_in,
    output logic                  rast_valid_out,
    output logic [10:0]           rast_hcount_out,
    output logic [9:0]            rast_vcount_out,
    output logic [15:0]           rast_depth_out,
    output logic [15:0]           rast_radius_out,
    output logic                  busy_out,
    output logic                  frame_done_out,
    output logic [ADDR_WIDTH:0]   issued_count_out,
    output logic [ADDR_WIDTH:0]   culled_count_out
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam int WW = $clog2(MEM_LATENCY + 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t                r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_index;
    logic [CW-1:0]         r_count, r_issued, r_culled, w_count;
    logic [WW-1:0]         r_wait;
    logic                  r_drain;
    logic [10:0]           r_hcount;
    logic [9:0]            r_vcount;
    logic [15:0]           r_depth, r_radius;
    logic                  w_start, w_wait_last, w_last, w_cull;

    assign w_start     = r_state == S_IDLE && frame_start_in;
    assign w_count     = particle_count_in > CW'(MAX_PARTICLES) ? CW'(MAX_PARTICLES) : particle_count_in;
    assign w_wait_last = r_wait == WW'(MEM_LATENCY - 1);
    assign w_last      = CW'(r_index) + CW'(1) == r_count;
    // Culling looks at the raw memory word on the final WAIT cycle, so a culled
    // record costs only FETCH plus the read latency.
    assign w_cull      = mem_data_in[52:42] >= 11'(WIDTH) || mem_data_in[41:32] >= 10'(HEIGHT)
                         || mem_data_in[15:0] == 16'd0;

    assign mem_addr_out     = r_index;
    assign rast_hcount_out  = r_hcount;
    assign rast_vcount_out  = r_vcount;
    assign rast_depth_out   = r_depth;
    assign rast_radius_out  = r_radius;
    assign issued_count_out = r_issued;
    assign culled_count_out = r_culled;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next         = r_state;
        mem_rd_out     = 1'b0;
        rast_valid_out = 1'b0;
        frame_done_out = 1'b0;
        busy_out       = r_state != S_IDLE;
        case (r_state)
            S_IDLE:  if (frame_start_in) w_next = w_count == '0 ? S_DONE : S_FETCH;
            S_FETCH: begin
                mem_rd_out = 1'b1;
                w_next     = S_WAIT;
            end
            S_WAIT:  if (w_wait_last) w_next = !w_cull ? S_ISSUE : w_last ? S_DRAIN : S_FETCH;
            S_ISSUE: if (rast_ready_in) begin
                rast_valid_out = 1'b1;
                w_next         = w_last ? S_DRAIN : S_FETCH;
            end
            // The first DRAIN cycle never samples ready, giving the rasterizer
            // time to drop ready_out after the last issue.
            S_DRAIN: if (r_drain && rast_ready_in) w_next = S_DONE;
            S_DONE:  begin
                frame_done_out = 1'b1;
                w_next         = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_count  <= '0;
            r_index  <= '0;
            r_issued <= '0;
            r_culled <= '0;
            r_wait   <= '0;
            r_drain  <= 1'b0;
            r_hcount <= '0;
            r_vcount <= '0;
            r_depth  <= '0;
            r_radius <= '0;
        end else begin
            if (w_start) begin
                r_count  <= w_count;
                r_index  <= '0;
                r_issued <= '0;
                r_culled <= '0;
            end
            if (r_state != S_IDLE && w_next == S_FETCH) r_index <= r_index + ADDR_WIDTH'(1);
            r_wait  <= (r_state == S_WAIT && !w_wait_last) ? r_wait + WW'(1) : '0;
            r_drain <= r_state == S_DRAIN;
            if (r_state == S_WAIT && w_wait_last) begin
                r_hcount <= mem_data_in[52:42];
                r_vcount <= mem_data_in[41:32];
                r_depth  <= mem_data_in[31:16];
                r_radius <= mem_data_in[15:0];
                r_culled <= r_culled + CW'(w_cull);
            end
            if (rast_valid_out) r_issued <= r_issued + CW'(1);
        end
    end
endmodule

// File: tb/tb_raster_scheduler.sv
// tb_raster_scheduler: directed + randomized bench for raster_scheduler against
// a cycle-timeline reference model built from the frame sequencing rules.
module tb_raster_scheduler;
    localparam int L    = 2;
    localparam int MAXP = 1024;
    localparam int AW   = 10;
    localparam int MAXC = 8192;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fs = 1'b0;
    logic [AW:0]   pc = '0;
    logic          rd, valid, busy, done;
    logic          ready = 1'b0;
    logic [AW-1:0] addr;
    logic [52:0]   mdata, p1, p2;
    logic [10:0]   hc;
    logic [9:0]    vc;
    logic [15:0]   dp, rr;
    logic [AW:0]   iss, cul;
    logic [52:0]   mem [MAXP];

    always #5 clk = ~clk;

    // Particle memory with MEM_LATENCY=2; junk on the bus when not reading.
    always @(posedge clk) begin
        p1 <= rd ? mem[addr] : 53'({$urandom(), $urandom()});
        p2 <= p1;
    end
    assign mdata = p2;

    raster_scheduler #(.MAX_PARTICLES(MAXP), .ADDR_WIDTH(AW), .WIDTH(320), .HEIGHT(180), .MEM_LATENCY(L)) dut (
        .clk_in(clk), .rst_in(rst_n), .frame_start_in(fs), .particle_count_in(pc),
        .mem_rd_out(rd), .mem_addr_out(addr), .mem_data_in(mdata),
        .rast_ready_in(ready), .rast_valid_out(valid),
        .rast_hcount_out(hc), .rast_vcount_out(vc), .rast_depth_out(dp), .rast_radius_out(rr),
        .busy_out(busy), .frame_done_out(done),
        .issued_count_out(iss), .culled_count_out(cul)
    );

    int checks = 0;
    int errors = 0;
    bit rdy [MAXC];
    bit e_valid [MAXC];
    bit e_rd [MAXC];
    int e_addr [MAXC];
    int e_fidx [MAXC];
    int e_done, e_iss, e_cul, obs_done, reads;
    int obs_valid [$];

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic logic [52:0] rec(input int h, input int v, input int d, input int r);
        return {11'(h), 10'(v), 16'(d), 16'(r)};
    endfunction

    function automatic logic [52:0] rand_in();
        return rec($urandom_range(0, 319), $urandom_range(0, 179), $urandom, $urandom_range(1, 65535));
    endfunction

    function automatic logic [52:0] rand_mix();
        int k = $urandom_range(0, 5);
        logic [52:0] x = rand_in();
        if (k == 0) x[52:42] = 11'($urandom_range(320, 2047));
        if (k == 1) x[41:32] = 10'($urandom_range(180, 1023));
        if (k == 2) x[15:0]  = 16'd0;
        return x;
    endfunction

    function automatic void rdy_fill(input int pct);
        for (int c = 0; c < MAXC; c++) rdy[c] = (c >= MAXC - 8) || ($urandom_range(0, 99) < pct);
    endfunction

    // Timeline model: FETCH, L WAIT cycles, then either skip (culled) or sit in
    // ISSUE until ready; after the last particle, DRAIN >= 2 cycles then DONE.
    function automatic void model(input int n);
        int t = 1;
        int c;
        for (int k = 0; k < MAXC; k++) begin
            e_valid[k] = 0; e_rd[k] = 0; e_addr[k] = 0; e_fidx[k] = -1;
        end
        e_iss = 0;
        e_cul = 0;
        for (int i = 0; i < n; i++) begin
            e_rd[t] = 1;
            e_addr[t] = i;
            if (mem[i][52:42] >= 320 || mem[i][41:32] >= 180 || mem[i][15:0] == 0) begin
                e_cul++;
                t += 1 + L;
            end else begin
                c = t + 1 + L;
                while (!rdy[c] && c < MAXC - 4) begin
                    e_fidx[c] = i;
                    c++;
                end
                e_fidx[c] = i;
                e_valid[c] = 1;
                e_iss++;
                t = c + 1;
            end
        end
        if (n == 0) e_done = 1;
        else begin
            c = t + 1;
            while (!rdy[c] && c < MAXC - 4) c++;
            e_done = c + 1;
        end
    endfunction

    task automatic run_frame(input int n_req, input int stop_at, input int fs2_at);
        int n = n_req > MAXP ? MAXP : n_req;
        model(n);
        obs_done = -1;
        obs_valid.delete();
        reads = 0;
        @(posedge clk); #1;
        fs = 1'b1;
        pc = (AW+1)'(n_req);
        ready = rdy[0];
        for (int c = 1; c <= e_done + 1; c++) begin
            @(posedge clk); #1;
            fs = (c == fs2_at);
            if (c == fs2_at) pc = 11'd3;
            ready = rdy[c];
            #1;
            if (c == stop_at) return;
            chk("valid", 64'(valid), 64'(e_valid[c]));
            if (valid) obs_valid.push_back(c);
            if (e_fidx[c] >= 0) chk("fields", 64'({hc, vc, dp, rr}), 64'(mem[e_fidx[c]]));
            chk("mem_rd", 64'(rd), 64'(e_rd[c]));
            if (e_rd[c]) chk("mem_addr", 64'(addr), 64'(e_addr[c]));
            if (rd) reads++;
            chk("busy", 64'(busy), 64'(c >= 1 && c <= e_done));
            chk("done", 64'(done), 64'(c == e_done));
            if (done) obs_done = c;
        end
        fs = 1'b0;
        chk("issued", 64'(iss), 64'(e_iss));
        chk("culled", 64'(cul), 64'(e_cul));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 64'(valid), 64'(0));
        chk({tag, "_rd"}, 64'(rd), 64'(0));
        chk({tag, "_addr"}, 64'(addr), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_counts"}, 64'({iss, cul}), 64'(0));
        chk({tag, "_fields"}, 64'({hc, vc, dp, rr}), 64'(0));
    endtask

    initial begin
        for (int i = 0; i < MAXP; i++) mem[i] = rand_in();
        // Reset state
        ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk_zero("reset");
        rst_n = 1'b1;
        // Four in-bounds particles, ready held high
        rdy_fill(100);
        run_frame(4, -1, -1);
        chk("t1_nvalid", 64'(obs_valid.size()), 64'(4));
        for (int i = 0; i < obs_valid.size() && i < 4; i++) chk("t1_issue_cycle", 64'(obs_valid[i]), 64'(4 + 4 * i));
        chk("t1_done_cycle", 64'(obs_done), 64'(19));
        chk("t1_counts", 64'({iss, cul}), 64'({11'd4, 11'd0}));
        // Culling set
        mem[0] = rec(10, 10, 100, 3);
        mem[1] = rec(320, 5, 200, 2);
        mem[2] = rec(5, 180, 300, 2);
        mem[3] = rec(7, 7, 400, 0);
        mem[4] = rec(319, 179, 500, 1);
        run_frame(5, -1, -1);
        chk("t2_counts", 64'({iss, cul}), 64'({11'd2, 11'd3}));
        chk("t2_nvalid", 64'(obs_valid.size()), 64'(2));
        // Ready low for 50 ISSUE cycles, then low again during DRAIN
        mem[0] = rand_in();
        mem[1] = rand_in();
        rdy_fill(100);
        for (int c = 4; c < 54; c++) rdy[c] = 0;
        for (int c = 59; c < 79; c++) rdy[c] = 0;
        run_frame(2, -1, -1);
        if (obs_valid.size() == 2) begin
            chk("t3_first_issue", 64'(obs_valid[0]), 64'(54));
            chk("t3_second_issue", 64'(obs_valid[1]), 64'(58));
        end else chk("t3_nvalid", 64'(obs_valid.size()), 64'(2));
        chk("t3_done_cycle", 64'(obs_done), 64'(80));
        // Empty frame
        rdy_fill(100);
        run_frame(0, -1, -1);
        chk("t4_done_cycle", 64'(obs_done), 64'(1));
        chk("t4_reads", 64'(reads), 64'(0));
        // Oversized count clamps to capacity; mid-frame start ignored
        for (int i = 0; i < MAXP; i++) mem[i] = rand_mix();
        rdy_fill(70);
        run_frame(2000, -1, 100);
        chk("t5_reads", 64'(reads), 64'(1024));
        chk("t5_total", 64'(iss + cul), 64'(1024));
        // Reset during WAIT of particle 2
        for (int i = 0; i < 8; i++) mem[i] = rand_in();
        rdy_fill(100);
        run_frame(4, 10, -1);
        rst_n = 1'b0;
        #1 chk_zero("midrst");
        repeat (3) begin
            @(posedge clk); #1;
            chk("midrst_nodone", 64'({busy, done}), 64'(0));
        end
        rst_n = 1'b1;
        rdy_fill(60);
        run_frame(6, -1, -1);
        // Random frames
        repeat (5) begin
            for (int i = 0; i < 32; i++) mem[i] = rand_mix();
            rdy_fill($urandom_range(30, 100));
            run_frame($urandom_range(1, 24), -1, -1);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
